// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter that time-shares one four-bit adder-subtractor.
// Each operation is IDLE (grant) -> EXEC (capture) -> DONE (done pulse) -> IDLE.

module four_bit_adder_subtractor (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic add_sub,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic carry_out
);

    logic yb0_s;
    logic yb1_s;
    logic yb2_s;
    logic yb3_s;
    logic c1_s;
    logic c2_s;
    logic c3_s;

    // Subtraction is a + ~b + 1: invert b and feed add_sub in as the carry.
    assign yb0_s = y0 ^ add_sub;
    assign yb1_s = y1 ^ add_sub;
    assign yb2_s = y2 ^ add_sub;
    assign yb3_s = y3 ^ add_sub;

    assign s0   = x0 ^ yb0_s ^ add_sub;
    assign c1_s = (x0 & yb0_s) | (add_sub & (x0 ^ yb0_s));

    assign s1   = x1 ^ yb1_s ^ c1_s;
    assign c2_s = (x1 & yb1_s) | (c1_s & (x1 ^ yb1_s));

    assign s2   = x2 ^ yb2_s ^ c2_s;
    assign c3_s = (x2 & yb2_s) | (c2_s & (x2 ^ yb2_s));

    assign s3        = x3 ^ yb3_s ^ c3_s;
    assign carry_out = (x3 & yb3_s) | (c3_s & (x3 ^ yb3_s));

endmodule

module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             gnt_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             op_q;
    logic             op_d;
    logic             last_gnt_q;
    logic             last_gnt_d;
    logic             gnt_q;
    logic             gnt_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             carry_q;
    logic             carry_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             done0_q;
    logic             done0_d;
    logic             done1_q;
    logic             done1_d;
    logic             busy_q;
    logic             busy_d;

    logic             win_s;
    logic             any_req_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;

    // Signed overflow: operands (b inverted for subtract) agree in sign but the result does not.
    function automatic logic ovf_fn(input logic a_msb, input logic b_msb,
                                    input logic s_msb, input logic sub);
        logic same_sign;
        same_sign = sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_sign && (s_msb != a_msb);
    endfunction

    four_bit_adder_subtractor u_alu (
        .x0       (a_q[0]),
        .x1       (a_q[1]),
        .x2       (a_q[2]),
        .x3       (a_q[3]),
        .y0       (b_q[0]),
        .y1       (b_q[1]),
        .y2       (b_q[2]),
        .y3       (b_q[3]),
        .add_sub  (op_q),
        .s0       (sum_s[0]),
        .s1       (sum_s[1]),
        .s2       (sum_s[2]),
        .s3       (sum_s[3]),
        .carry_out(cout_s)
    );

    // Round-robin winner: a lone request wins outright, a tie goes to the one not served last.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            win_s = ~last_gnt_q;
        end else begin
            win_s = req1;
        end
    end

    // Next-state and next-output logic; every output register is held unless a state updates it.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        result_d   = result_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    a_d        = win_s ? a1 : a0;
                    b_d        = win_s ? b1 : b0;
                    op_d       = win_s ? op1 : op0;
                    gnt_d      = win_s;
                    last_gnt_d = win_s;
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d = sum_s;
                carry_d  = cout_s;
                ovf_d    = ovf_fn(a_q[WIDTH-1], b_q[WIDTH-1], sum_s[WIDTH-1], op_q);
                done0_d  = ~gnt_q;
                done1_d  = gnt_q;
                busy_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign gnt_id    = gnt_q;
    assign busy      = busy_q;

endmodule
